// File: rtl/game_pkg.sv
// game_pkg: shared game-state encodings, sequencer states and move-period helper
package game_pkg;
  localparam logic [1:0] ST_RESET = 2'b00;
  localparam logic [1:0] ST_LEVEL_INCREMENT = 2'b01;
  localparam logic [1:0] ST_GAME_OVER = 2'b10;
  localparam logic [1:0] ST_WINNING = 2'b11;
  localparam int MAX_LEVEL = 8;
  typedef enum logic [1:0] {IDLE, PLAY, RESPAWN, HOLD} seq_state_t;
  function automatic logic [23:0] move_div(input logic [3:0] lvl, input logic [23:0] base, input logic [23:0] step, input logic [23:0] min_div);
    logic [3:0] l;
    logic [23:0] red;
    l = lvl > 4'(MAX_LEVEL) ? 4'(MAX_LEVEL) : lvl;
    red = 24'(l) * step;
    return (red < base && base - red > min_div) ? base - red : min_div;
  endfunction
endpackage

// File: rtl/level_sequencer_if.sv
// level_sequencer_if: game-state inputs and sequencer outputs of the level sequencer
interface level_sequencer_if;
  logic [1:0] game_state;
  logic [3:0] current_level;
  logic player_at_goal;
  logic player_hit;
  logic move_tick;
  logic level_complete;
  logic game_over_signal;
  logic respawn;
  logic [1:0] lives;
  logic [4:0] time_left;
  modport master(output game_state, current_level, player_at_goal, player_hit,
                 input move_tick, level_complete, game_over_signal, respawn, lives, time_left);
  modport slave(input game_state, current_level, player_at_goal, player_hit,
                output move_tick, level_complete, game_over_signal, respawn, lives, time_left);
endinterface

// File: rtl/tick_divider.sv
// tick_divider: runtime-divisor wrap strobe; the divisor is latched at each wrap or clear
module tick_divider #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         wrap
);
  logic [W-1:0] cnt, per;
  assign wrap = en && !clr && cnt == per - 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      per <= '0;
    end else begin
      cnt <= clr || wrap ? '0 : en ? cnt + 1'b1 : cnt;
      per <= clr || wrap ? div : per;
    end
endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: lives, level timer and obstacle tick; turns player events into single pulses
module level_sequencer import game_pkg::*; #(
  parameter int CLK_HZ = 25_000_000,
  parameter int BASE_TICK_DIV = 12_500_000,
  parameter int TICK_STEP_DIV = 1_250_000,
  parameter int MIN_TICK_DIV = 2_500_000,
  parameter int LEVEL_TIME_S = 30,
  parameter int START_LIVES = 3,
  parameter int RESPAWN_CYCLES = 25_000_000
) (
  input logic clk,
  input logic reset,
  level_sequencer_if.slave bus
);
  localparam int SW = $clog2(CLK_HZ) + 1;
  localparam int RW = $clog2(RESPAWN_CYCLES) + 1;
  seq_state_t state, nxt;
  logic [RW-1:0] rcnt;
  logic [23:0] mdiv;
  logic run, in_play, move_wrap, sec_wrap, timeout, goal, fail;
  logic mt_d, lc_d, go_d, rs_d;
  logic [1:0] lives_d;
  logic [4:0] time_d;
  assign run = state == PLAY;
  assign in_play = run && bus.game_state == ST_LEVEL_INCREMENT;
  assign timeout = sec_wrap && bus.time_left == 5'd1;
  assign goal = in_play && bus.player_at_goal;
  assign fail = in_play && !bus.player_at_goal && (bus.player_hit || timeout);
  assign mdiv = move_div(bus.current_level, 24'(BASE_TICK_DIV), 24'(TICK_STEP_DIV), 24'(MIN_TICK_DIV));
  tick_divider #(.W(24)) u_move (.clk, .reset, .en(run), .clr(!run), .div(mdiv), .wrap(move_wrap));
  tick_divider #(.W(SW)) u_sec (.clk, .reset, .en(run), .clr(!run), .div(SW'(CLK_HZ)), .wrap(sec_wrap));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rcnt <= '0;
      bus.move_tick <= 1'b0;
      bus.level_complete <= 1'b0;
      bus.game_over_signal <= 1'b0;
      bus.respawn <= 1'b0;
      bus.lives <= 2'(START_LIVES);
      bus.time_left <= 5'(LEVEL_TIME_S);
    end else begin
      state <= nxt;
      rcnt <= state == RESPAWN ? rcnt + 1'b1 : '0;
      bus.move_tick <= mt_d;
      bus.level_complete <= lc_d;
      bus.game_over_signal <= go_d;
      bus.respawn <= rs_d;
      bus.lives <= lives_d;
      bus.time_left <= time_d;
    end
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = bus.game_state == ST_LEVEL_INCREMENT ? PLAY : IDLE;
    else if (bus.game_state != ST_LEVEL_INCREMENT) nxt = IDLE;
    else if (state == PLAY) nxt = goal ? HOLD : fail ? (bus.lives > 2'd1 ? RESPAWN : HOLD) : PLAY;
    else if (state == RESPAWN && rcnt == RW'(RESPAWN_CYCLES - 1)) nxt = PLAY;
  end
  // goal outranks hit/timeout, and no time decrement is taken on a goal cycle
  always_comb begin
    lc_d = goal;
    go_d = fail && bus.lives <= 2'd1;
    rs_d = fail && bus.lives > 2'd1;
    mt_d = move_wrap && nxt == PLAY;
    lives_d = bus.lives;
    time_d = bus.time_left;
    if (state == IDLE) begin
      time_d = 5'(LEVEL_TIME_S);
      lives_d = bus.game_state == ST_RESET ? 2'(START_LIVES) : bus.lives;
    end else if (go_d) lives_d = 2'd0;
    else if (rs_d) begin
      lives_d = bus.lives - 2'd1;
      time_d = 5'(LEVEL_TIME_S);
    end else if (in_play && !goal && sec_wrap) time_d = bus.time_left == 5'd0 ? 5'd0 : bus.time_left - 5'd1;
  end
endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
Runtime sequencer that drives the game state machine during a level. It owns the lives counter, the per-level countdown timer and the obstacle movement tick, whose period shortens as current_level rises. It converts raw player events (goal reached, collision) into one-cycle level_complete / game_over_signal pulses for game_states, and issues respawn requests to the player controller.

Parameters:
CLK_HZ, 25_000_000, clocks per second; drives the time_left decrement.
BASE_TICK_DIV, 12_500_000, move_tick period in clocks at level 0.
TICK_STEP_DIV, 1_250_000, period reduction per level.
MIN_TICK_DIV, 2_500_000, lower clamp on move_tick period.
LEVEL_TIME_S, 30, seconds allowed per life/attempt (max 31).
START_LIVES, 3, lives at new game (1..3).
RESPAWN_CYCLES, 25_000_000, freeze length after losing a life.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
game_state  in  2  current_state from game_states (00 RESET, 01 LEVEL_INCREMENT, 10 GAME_OVER, 11 WINNING_SCREEN)
current_level  in  4  level from game_states (0..8)
player_at_goal  in  1  level-sensitive, player occupies goal row
player_hit  in  1  level-sensitive, player collides with obstacle
move_tick  out  1  one-cycle obstacle step strobe
level_complete  out  1  one-cycle pulse to game_states
game_over_signal  out  1  one-cycle pulse to game_states
respawn  out  1  one-cycle pulse; player returns to start
lives  out  2  remaining lives
time_left  out  5  seconds remaining

Behaviour:
- Reset (async, clk-independent): state IDLE, lives=START_LIVES, time_left=LEVEL_TIME_S, all pulses 0, both prescalers 0.
- Registered outputs; every pulse is exactly one clk wide.
- States: IDLE, PLAY, RESPAWN, HOLD.
- IDLE: prescalers held at 0, time_left=LEVEL_TIME_S. If game_state==00, lives reloads to START_LIVES. If game_state==01, go to PLAY next cycle.
- Any state other than IDLE: if game_state != 01, go to IDLE next cycle. No pulse is issued on that cycle.
- PLAY, move prescaler: div = max(BASE_TICK_DIV - L*TICK_STEP_DIV, MIN_TICK_DIV), where L = min(current_level, 8). Use 24-bit unsigned arithmetic; compute with a compare, never wrap negative.
- The prescaler counts 0..div-1. move_tick fires on the cycle the count wraps.
- div is sampled at each wrap, so a level change mid-period takes effect on the next period.
- PLAY, second prescaler: counts 0..CLK_HZ-1 and decrements time_left on wrap. time_left saturates at 0.
- Timeout: the wrap that takes time_left from 1 to 0.
- PLAY event priority in the same cycle: goal > hit > timeout.
  - goal: level_complete pulse, go to HOLD.
  - hit or timeout with lives==1: lives=0, game_over_signal pulse, go to HOLD.
  - hit or timeout with lives>1: lives decrements, respawn pulse, time_left=LEVEL_TIME_S, both prescalers cleared, go to RESPAWN.
- RESPAWN: counts RESPAWN_CYCLES clocks, then returns to PLAY. During RESPAWN:
  - move_tick is suppressed;
  - player_at_goal and player_hit are ignored;
  - time_left is frozen.
- HOLD: all pulses stay 0; lives and time_left are frozen. Only exit is game_state leaving 01. Guarantees one pulse per event even though inputs remain asserted.
- Reset mid-RESPAWN or mid-PLAY aborts immediately to the reset values; no pulse is emitted.

Decomposition:
- Shared package game_pkg:
  - game-state encodings (ST_RESET, ST_LEVEL_INCREMENT, ST_GAME_OVER, ST_WINNING);
  - MAX_LEVEL=8;
  - sequencer state encoding.
- One sub-module, tick_divider: runtime-divisor pulse generator with enable and clear. It is instantiated twice, once for the move tick and once for seconds.

Test Plan:
Test parameters for all scenarios: CLK_HZ=10, BASE_TICK_DIV=8, TICK_STEP_DIV=1, MIN_TICK_DIV=4, LEVEL_TIME_S=3, START_LIVES=3, RESPAWN_CYCLES=5.
1. Assert reset mid-run -> lives=3, time_left=3 and all pulses 0 on the same cycle, before any clk edge.
2. game_state 00 then 01, level 0 -> first move_tick 8 clocks after entering PLAY, then every 8. At level 2, every 6. At level 7, clamped to every 4.
3. game_state=01, no events, 30 clocks in PLAY -> time_left 3→2→1→0. respawn pulse, lives=2, time_left=3, then 5 clocks with no move_tick.
4. Three successive player_hit held high -> respawn, respawn, then a single game_over_signal pulse. lives=0; no further pulse while hit stays high in HOLD.
5. player_at_goal and player_hit asserted on the same cycle -> level_complete pulse only; lives unchanged.
6. game_state=11 for 3 cycles, then 01 -> HOLD→IDLE→PLAY. time_left=3, lives retained (not reloaded), new pulses possible.
